// File: rtl/accum_pkg.sv
// Shared definitions for the accumulate coprocessor:
// FSM state encoding, signed saturation bounds, default geometry
// and the accumulate adders (wrapping and saturating).
package accum_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int RD_LAT_DEF = 2;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Two's complement add, result taken modulo 2^32.
  function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  // Signed add clamped to SAT_MAX / SAT_MIN when the operands share a sign
  // and the raw sum does not.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    if ((a[31] == b[31]) && (s[31] != a[31])) begin
      return a[31] ? SAT_MIN : SAT_MAX;
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/accum_rdvalid_pipe.sv
// Read-valid delay line: one bit per cycle of RAM latency. A read issued
// in cycle n shows up on 'valid' in cycle n+RD_LAT. The line always
// shifts (it is not gated by the custom-instruction clock enable) because
// the RAM returns data on its own schedule.
module accum_rdvalid_pipe
  import accum_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic valid
);

  logic [RD_LAT-1:0] r_vld;

  // Shift the issue flag down the line; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= issue;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  assign valid = r_vld[RD_LAT-1];

endmodule

// File: rtl/accum_coprocessor.sv
// Nios custom-instruction coprocessor: sums 'datab' consecutive words of
// a data RAM starting at address 'dataa' and returns the signed total.
// Build option: define ACCUM_SATURATE_EN to clamp each addition on signed
// overflow instead of wrapping modulo 2^32.
module accum_coprocessor
  import accum_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [31:0]       dataa,
  input  logic [31:0]       datab,
  output logic [31:0]       result,
  output logic              done,
  output logic [ADDR_W-1:0] rdaddress,
  output logic              rden,
  input  logic [31:0]       rddata
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int PEND_W = 3;
  // Largest legal transfer: the whole RAM once.
  localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] ONE_CNT = {{ADDR_W{1'b0}}, 1'b1};

  state_e             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_remain;
  logic [31:0]        r_acc;
  logic [31:0]        r_result;
  logic               r_done;
  logic [PEND_W-1:0]  r_pend;

  logic               w_issue;
  logic               w_valid;
  logic               w_drained;
  logic [CNT_W-1:0]   w_req_cnt;
  logic [31:0]        w_sum;
  logic [31:0]        w_acc_next;
  logic [PEND_W-1:0]  w_pend_next;
  logic               w_unused_bits;

  // Upper operand bits carry no meaning for this RAM size.
  assign w_unused_bits = ^{dataa[31:ADDR_W], datab[31:CNT_W]};

  // Requested word count, clamped so a transfer never laps the RAM.
  always_comb begin
    w_req_cnt = datab[ADDR_W:0];
    if (datab[ADDR_W:0] > MAX_CNT) begin
      w_req_cnt = MAX_CNT;
    end else begin
      w_req_cnt = datab[ADDR_W:0];
    end
  end

  // A read goes out only in ISSUE and only while the CPU enables us.
  assign w_issue = (r_state == ST_ISSUE) && clk_en;

  accum_rdvalid_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rdvalid (
    .clk   (clk),
    .reset (reset),
    .issue (w_issue),
    .valid (w_valid)
  );

  // Accumulator adder and next value; data is folded in the cycle it arrives.
  always_comb begin
`ifdef ACCUM_SATURATE_EN
    w_sum = sat_add(r_acc, rddata);
`else
    w_sum = wrap_add(r_acc, rddata);
`endif
    if (w_valid) begin
      w_acc_next = w_sum;
    end else begin
      w_acc_next = r_acc;
    end
  end

  // Outstanding-read bookkeeping; drained once the only read left is the
  // one returning right now.
  always_comb begin
    w_pend_next = r_pend + PEND_W'(w_issue) - PEND_W'(w_valid);
    if (r_pend == PEND_W'(w_valid)) begin
      w_drained = 1'b1;
    end else begin
      w_drained = 1'b0;
    end
  end

  // Free-running in-flight counter and accumulator (not gated by clk_en).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= {PEND_W{1'b0}};
      r_acc  <= 32'd0;
    end else begin
      r_pend <= w_pend_next;
      if ((r_state == ST_IDLE) && clk_en && start) begin
        r_acc <= 32'd0;
      end else begin
        r_acc <= w_acc_next;
      end
    end
  end

  // Control FSM: every state change is qualified by clk_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= {ADDR_W{1'b0}};
      r_remain <= {CNT_W{1'b0}};
      r_result <= 32'd0;
      r_done   <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_addr   <= dataa[ADDR_W-1:0];
            r_remain <= w_req_cnt;
            if (w_req_cnt == {CNT_W{1'b0}}) begin
              r_state  <= ST_FINISH;
              r_result <= 32'd0;
              r_done   <= 1'b1;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // Address increment wraps naturally at ADDR_W bits.
          r_addr   <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          r_remain <= r_remain - ONE_CNT;
          if (r_remain == ONE_CNT) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state  <= ST_FINISH;
            r_result <= w_acc_next;
            r_done   <= 1'b1;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign result    = r_result;
  assign done      = r_done;
  assign rdaddress = r_addr;
  assign rden      = w_issue;

endmodule
